// File: rtl/operand_fetch.sv
// operand_fetch: LC-3 register-file initiator with an 8-entry pending-write scoreboard.
// Decodes source/destination fields, primes RegFile reads, and turns writebacks into ld_reg pulses.
module operand_fetch #(
  parameter bit WAW_STALL = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  input  logic [15:0] SR1out,
  input  logic [15:0] SR2out,
  output logic [2:0]  DR,
  output logic [15:0] data,
  output logic        ld_reg,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [15:0] op_ir,
  output logic [2:0]  op_dr,
  output logic        op_wr,
  input  logic        wb_valid,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic        wb_ready
);

  typedef enum logic [2:0] {S_IDLE, S_HAZARD, S_PRIME, S_SETTLE, S_VALID} state_t;

  typedef struct packed {
    logic       use1;
    logic       use2;
    logic       wr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d;
    d = '0;
    case (ir[15:12])
      4'b0001, 4'b0101: begin  // ADD, AND
        d.use1 = 1'b1;
        d.sr1  = ir[8:6];
        d.use2 = ~ir[5];
        d.sr2  = ir[5] ? 3'd0 : ir[2:0];
        d.wr   = 1'b1;
        d.dr   = ir[11:9];
      end
      4'b1001, 4'b0110: begin  // NOT, LDR
        d.use1 = 1'b1;
        d.sr1  = ir[8:6];
        d.wr   = 1'b1;
        d.dr   = ir[11:9];
      end
      4'b0111: begin  // STR
        d.use1 = 1'b1;
        d.sr1  = ir[8:6];
        d.use2 = 1'b1;
        d.sr2  = ir[11:9];
      end
      4'b0011, 4'b1011: begin  // ST, STI
        d.use2 = 1'b1;
        d.sr2  = ir[11:9];
      end
      4'b1100: begin  // JMP
        d.use1 = 1'b1;
        d.sr1  = ir[8:6];
      end
      4'b0100: begin  // JSR / JSRR
        d.use1 = ~ir[11];
        d.sr1  = ir[11] ? 3'd0 : ir[8:6];
        d.wr   = 1'b1;
        d.dr   = 3'd7;
      end
      4'b0010, 4'b1010, 4'b1110: begin  // LD, LDI, LEA
        d.wr = 1'b1;
        d.dr = ir[11:9];
      end
      4'b1111: begin  // TRAP
        d.wr = 1'b1;
        d.dr = 3'd7;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t      state_r;
  dec_t        dec_r;
  logic [15:0] ir_r;
  logic [7:0]  pending_r;
  logic [7:0]  pend_clr_s;
  logic [7:0]  pend_nxt_s;
  logic        hazard_s;

  assign instr_ready = reset_n && (state_r == S_IDLE);
  assign wb_ready    = reset_n && !ld_reg;

  // Scoreboard next state; the hazard check sees a clear landing this edge so PRIME follows immediately.
  always_comb begin
    pend_clr_s = pending_r;
    if (ld_reg) begin
      pend_clr_s[DR] = 1'b0;
    end else begin
      pend_clr_s = pending_r;
    end
    pend_nxt_s = pend_clr_s;
    if ((state_r == S_VALID) && op_ready && op_wr) begin
      pend_nxt_s[op_dr] = 1'b1;
    end else begin
      pend_nxt_s = pend_clr_s;
    end
    hazard_s = (dec_r.use1 && pend_clr_s[dec_r.sr1]) ||
               (dec_r.use2 && pend_clr_s[dec_r.sr2]) ||
               (WAW_STALL && dec_r.wr && pend_clr_s[dec_r.dr]);
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_r <= 8'd0;
    end else begin
      pending_r <= pend_nxt_s;
    end
  end

  // Writeback path: one-cycle ld_reg pulse, DR/data held until the next accepted writeback.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ld_reg <= 1'b0;
      DR     <= 3'd0;
      data   <= 16'd0;
    end else if (wb_valid && !ld_reg) begin
      ld_reg <= 1'b1;
      DR     <= wb_dr;
      data   <= wb_data;
    end else begin
      ld_reg <= 1'b0;
    end
  end

  // Issue FSM; the complemented select in HAZARD forces RegFile to re-evaluate an unchanged select.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      dec_r    <= '0;
      ir_r     <= 16'd0;
      SR1      <= 3'd0;
      SR2      <= 3'd0;
      op_valid <= 1'b0;
      op_a     <= 16'd0;
      op_b     <= 16'd0;
      op_ir    <= 16'd0;
      op_dr    <= 3'd0;
      op_wr    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            ir_r    <= instr;
            dec_r   <= decode(instr);
            state_r <= S_HAZARD;
          end
        end
        S_HAZARD: begin
          if (!hazard_s) begin
            SR1     <= ~dec_r.sr1;
            SR2     <= ~dec_r.sr2;
            state_r <= S_PRIME;
          end
        end
        S_PRIME: begin
          SR1     <= dec_r.sr1;
          SR2     <= dec_r.sr2;
          state_r <= S_SETTLE;
        end
        S_SETTLE: begin
          op_a     <= dec_r.use1 ? SR1out : 16'd0;
          op_b     <= dec_r.use2 ? SR2out : 16'd0;
          op_ir    <= ir_r;
          op_dr    <= dec_r.dr;
          op_wr    <= dec_r.wr;
          op_valid <= 1'b1;
          state_r  <= S_VALID;
        end
        S_VALID: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: behavioural RegFile, architectural register/pending model,
// directed LC-3 cases plus randomized instruction/writeback traffic.
module tb_operand_fetch;
  localparam bit WAW = 1'b1;

  logic        clock = 1'b0;
  logic        reset_n, instr_valid, instr_ready, ld_reg, op_valid, op_ready, op_wr;
  logic        wb_valid, wb_ready;
  logic [15:0] instr, SR1out, SR2out, data, op_a, op_b, op_ir, wb_data;
  logic [2:0]  SR1, SR2, DR, op_dr, wb_dr;
  logic [15:0] rf [8];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ir;
    logic [2:0]  dr;
    logic        wr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rf_m [8];
  logic [7:0]  pend_m;
  bit          mon_en;
  int          checks_total = 0;
  int          checks_pass  = 0;

  always #5 clock = ~clock;

  operand_fetch #(.WAW_STALL(WAW)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .SR1(SR1), .SR2(SR2), .SR1out(SR1out), .SR2out(SR2out),
    .DR(DR), .data(data), .ld_reg(ld_reg), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_ir(op_ir), .op_dr(op_dr), .op_wr(op_wr),
    .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  // Behavioural RegFile: combinational reads, write on the rising edge of ld_reg.
  assign SR1out = rf[SR1];
  assign SR2out = rf[SR2];
  always @(posedge ld_reg) begin
    #1;
    rf[DR] <= data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Which fields an LC-3 instruction reads and writes.
  task automatic bdec(input logic [15:0] ir, output bit u1, output bit u2, output bit wr,
                      output logic [2:0] s1, output logic [2:0] s2, output logic [2:0] d);
    logic [3:0] op;
    op = ir[15:12];
    u1 = 1'b0; u2 = 1'b0; wr = 1'b0; s1 = ir[8:6]; s2 = 3'd0; d = 3'd0;
    u1 = (op inside {4'h1, 4'h5, 4'h9, 4'h6, 4'h7, 4'hC}) || (op == 4'h4 && !ir[11]);
    if ((op == 4'h1 || op == 4'h5) && !ir[5]) begin u2 = 1'b1; s2 = ir[2:0]; end
    else if (op inside {4'h3, 4'hB, 4'h7}) begin u2 = 1'b1; s2 = ir[11:9]; end
    if (op inside {4'h1, 4'h5, 4'h9, 4'h2, 4'hA, 4'h6, 4'hE}) begin wr = 1'b1; d = ir[11:9]; end
    else if (op == 4'h4 || op == 4'hF) begin wr = 1'b1; d = 3'd7; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (!instr_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("instr_ready_wait", 32'(instr_ready), 32'h1);
  endtask

  // One writeback handshake with pulse-shape checks; does not touch the model.
  task automatic wb(input logic [2:0] r, input logic [15:0] v);
    @(negedge clock);
    wb_valid = 1'b1; wb_dr = r; wb_data = v;
    chk("wb_ready_free", 32'(wb_ready), 32'h1);
    @(negedge clock);
    chk("ld_reg_high", 32'(ld_reg), 32'h1);
    chk("DR", 32'(DR), 32'(r));
    chk("data", 32'(data), 32'(v));
    chk("wb_ready_busy", 32'(wb_ready), 32'h0);
    wb_valid = 1'b0; wb_dr = 3'($urandom); wb_data = 16'($urandom);
    @(negedge clock);
    chk("ld_reg_one_cycle", 32'(ld_reg), 32'h0);
    chk("wb_ready_back", 32'(wb_ready), 32'h1);
    chk("DR_hold", 32'(DR), 32'(r));
    chk("data_hold", 32'(data), 32'(v));
    chk("regfile_write", 32'(rf[r]), 32'(v));
  endtask

  task automatic wb_model(input logic [2:0] r, input logic [15:0] v);
    wait_idle();
    wb(r, v);
    rf_m[r] = v;
    pend_m[r] = 1'b0;
  endtask

  // Issue one instruction: resolve its hazards in the model, push the expectation, drive it, then
  // perform the writebacks it waits for and check stall release timing.
  task automatic issue(input logic [15:0] ir, input bit fixed, input logic [15:0] fval);
    bit u1, u2, wr;
    logic [2:0] s1, s2, d;
    logic [7:0] hz;
    logic [15:0] nv [8];
    exp_t e;
    int n;
    bdec(ir, u1, u2, wr, s1, s2, d);
    wait_idle();
    hz = 8'h0;
    if (u1) hz = hz | (pend_m & (8'h1 << s1));
    if (u2) hz = hz | (pend_m & (8'h1 << s2));
    if (WAW && wr) hz = hz | (pend_m & (8'h1 << d));
    for (int r = 0; r < 8; r++) begin
      nv[r] = 16'h0;
      if (hz[r]) begin
        nv[r] = fixed ? fval : 16'($urandom);
        rf_m[r] = nv[r];
        pend_m[r] = 1'b0;
      end
    end
    e.a = u1 ? rf_m[s1] : 16'h0;
    e.b = u2 ? rf_m[s2] : 16'h0;
    e.ir = ir; e.dr = d; e.wr = wr;
    exp_q.push_back(e);
    if (wr) pend_m[d] = 1'b1;
    instr_valid = 1'b1; instr = ir;
    @(posedge clock);
    #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    if (hz == 8'h0) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!op_valid && n < 40);
      chk("issue_latency", 32'(n), 32'd4);
    end else begin
      repeat (3 + $urandom_range(0, 4)) @(negedge clock);
      for (int r = 0; r < 8; r++) if (hz[r]) wb(3'(r), nv[r]);
      chk("stall_hold", 32'(op_valid), 32'h0);
      n = 0;
      do begin @(negedge clock); n++; end while (!op_valid && n < 40);
      chk("release_latency", 32'(n), 32'd2);
    end
  endtask

  // Monitor: random backpressure, stability while valid, pop-and-compare at each handshake.
  initial begin : monitor
    exp_t e;
    logic [15:0] h_a, h_b, h_ir;
    logic [2:0]  h_dr;
    logic        h_wr;
    bit          h_v;
    h_v = 1'b0; h_a = 16'h0; h_b = 16'h0; h_ir = 16'h0; h_dr = 3'd0; h_wr = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en && op_valid) begin
        if (h_v) begin
          chk("op_ab_stable", {op_a, op_b}, {h_a, h_b});
          chk("op_ir_stable", 32'({op_ir, op_dr, op_wr}), 32'({h_ir, h_dr, h_wr}));
        end
        h_v = 1'b1; h_a = op_a; h_b = op_b; h_ir = op_ir; h_dr = op_dr; h_wr = op_wr;
        op_ready = ($urandom_range(0, 2) != 0);
        if (op_ready) begin
          chk("op_expected", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("op_a", 32'(op_a), 32'(e.a));
            chk("op_b", 32'(op_b), 32'(e.b));
            chk("op_ir", 32'(op_ir), 32'(e.ir));
            chk("op_wr", 32'(op_wr), 32'(e.wr));
            if (e.wr) chk("op_dr", 32'(op_dr), 32'(e.dr));
          end
          h_v = 1'b0;
        end
      end else begin
        h_v = 1'b0;
        op_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [15:0] v;
    reset_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; wb_valid = 1'b0; wb_dr = 3'd0;
    wb_data = 16'h0; op_ready = 1'b0; mon_en = 1'b0; pend_m = 8'h0;
    repeat (3) @(negedge clock);
    chk("rst_instr_ready", 32'(instr_ready), 32'h0);
    chk("rst_wb_ready", 32'(wb_ready), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_ld_reg", 32'(ld_reg), 32'h0);
    chk("rst_selects", 32'({SR1, SR2, DR}), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_op_ab", {op_a, op_b}, 32'h0);
    chk("rst_op_misc", 32'({op_ir, op_dr, op_wr}), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rel_instr_ready", 32'(instr_ready), 32'h1);
    chk("rel_wb_ready", 32'(wb_ready), 32'h1);
    @(posedge clock); #1 mon_en = 1'b1;

    for (int r = 0; r < 8; r++)
      wb_model(3'(r), (r == 1) ? 16'h0005 : (r == 2) ? 16'h0003 : 16'($urandom));

    issue(16'h1642, 1'b0, 16'h0);    // ADD R3,R1,R2
    issue(16'h18C3, 1'b1, 16'h0008); // ADD R4,R3,R3 waits on R3
    issue(16'h9A7F, 1'b0, 16'h0);    // NOT R5,R1
    wb_model(3'd1, 16'h1234);
    issue(16'h9A7F, 1'b0, 16'h0);    // same select, fresh value
    issue(16'h1261, 1'b0, 16'h0);    // ADD R1,R1,#1
    issue(16'h7440, 1'b0, 16'h0);    // STR R2,R1,#0
    issue(16'hE005, 1'b0, 16'h0);    // LEA R0
    issue(16'h4080, 1'b0, 16'h0);    // JSRR R2
    issue(16'h4800, 1'b0, 16'h0);    // JSR
    issue(16'hF025, 1'b0, 16'h0);    // TRAP
    issue(16'h0E01, 1'b0, 16'h0);    // BR
    issue(16'hC1C0, 1'b0, 16'h0);    // JMP R7
    issue(16'h1C42, 1'b0, 16'h0);    // ADD R6,R1,R2
    issue(16'h1842, 1'b0, 16'h0);    // ADD R4,R1,R2

    // Reset during SETTLE, with a writeback offered while reset is low.
    wait_idle();
    @(posedge clock); #1 mon_en = 1'b0;
    @(negedge clock);
    instr_valid = 1'b1; instr = 16'h0E01;
    @(posedge clock); #1 instr_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0; wb_valid = 1'b1; wb_dr = 3'd2; wb_data = 16'hDEAD;
    #1;
    chk("mid_wb_ready", 32'(wb_ready), 32'h0);
    chk("mid_instr_ready", 32'(instr_ready), 32'h0);
    @(negedge clock);
    chk("mid_op_valid", 32'(op_valid), 32'h0);
    chk("mid_ld_reg", 32'(ld_reg), 32'h0);
    @(negedge clock);
    chk("mid_no_pulse", 32'(ld_reg), 32'h0);
    chk("mid_DR_data", 32'({DR, data}), 32'h0);
    wb_valid = 1'b0; reset_n = 1'b1;
    pend_m = 8'h0;

    // Reset landing in the ld_reg cycle truncates the pulse.
    v = 16'($urandom);
    @(negedge clock);
    wb_valid = 1'b1; wb_dr = 3'd6; wb_data = v;
    @(negedge clock);
    chk("trunc_pulse_high", 32'(ld_reg), 32'h1);
    reset_n = 1'b0; wb_valid = 1'b0;
    @(negedge clock);
    chk("trunc_pulse_low", 32'(ld_reg), 32'h0);
    chk("trunc_op_valid", 32'(op_valid), 32'h0);
    chk("trunc_regfile", 32'(rf[6]), 32'(v));
    rf_m[6] = v;
    reset_n = 1'b1;
    @(posedge clock); #1 mon_en = 1'b1;
    issue(16'h9BBF, 1'b0, 16'h0);    // NOT R5,R6: no stall after reset
    issue(16'h9B3F, 1'b0, 16'h0);    // NOT R5,R4

    repeat (150) begin
      if ($urandom_range(0, 3) == 0) wb_model(3'($urandom), 16'($urandom));
      issue(16'($urandom), 1'b0, 16'h0);
    end
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-file initiator for the LC-3 datapath: accepts instruction words, decodes LC-3 source and destination fields, and drives `SR1`/`SR2`/`DR`/`ld_reg`/`data` into `RegFile`. Captures the returned operands and hands them downstream with a valid/ready handshake. Accepts writeback requests and converts each into a clean one-cycle `ld_reg` pulse. An 8-entry pending scoreboard stalls issue while a source or destination register awaits writeback.

## Interface
- `WAW_STALL`, default 1: when 1, issue also stalls while the destination register is pending; when 0, only sources are checked.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  16  LC-3 instruction word.
- `instr_ready`  out  1  block accepts an instruction this cycle.
- `SR1`, `SR2`  out  3  register-file read selects.
- `SR1out`, `SR2out`  in  16  register-file read data.
- `DR`  out  3  register-file write select.
- `data`  out  16  register-file write data.
- `ld_reg`  out  1  register-file write strobe, rising-edge active.
- `op_valid`  out  1  operands available.
- `op_ready`  in  1  downstream accepts operands.
- `op_a`, `op_b`  out  16  operand values; 0 when the field is unused.
- `op_ir`  out  16  instruction carried with the operands.
- `op_dr`  out  3  destination register.
- `op_wr`  out  1  the instruction writes `op_dr`.
- `wb_valid`  in  1  writeback offered.
- `wb_dr`  in  3  writeback register.
- `wb_data`  in  16  writeback value.
- `wb_ready`  out  1  writeback accepted this cycle.

## Operation
- **Decode**, with `op = ir[15:12]`:
  - `SR1 = ir[8:6]` for ADD, AND, NOT, LDR, STR, JMP, and JSRR (`0100` with `ir[11]=0`).
  - `SR2 = ir[2:0]` for ADD/AND with `ir[5]=0`.
  - `SR2 = ir[11:9]` for ST, STI, STR.
  - Destination `ir[11:9]` for ADD, AND, NOT, LD, LDI, LDR, LEA.
  - Destination R7 for JSR/JSRR and TRAP.
  - All other opcodes: no sources used, `op_wr=0`.
- **Issue FSM**:
  - IDLE: `instr_ready=1`. On `instr_valid`, latch `instr` and decoded fields, go to HAZARD.
  - HAZARD: stall while any used source is pending, or (if `WAW_STALL`) the destination is pending. When clear, register `SR1`/`SR2` to the bitwise complement of their target fields and go to PRIME.
  - PRIME: register `SR1`/`SR2` to the target fields and go to SETTLE. The complement step forces the register file's read outputs to re-evaluate even when the select value is unchanged.
  - SETTLE: latch `op_a=SR1out`, `op_b=SR2out` (zero if unused), plus `op_ir`, `op_dr`, `op_wr`. Go to VALID.
  - VALID: `op_valid=1`, with all `op_*` outputs stable. On `op_ready`, set `pending[op_dr]` if `op_wr`, then go to IDLE.
- **Writeback**:
  - `wb_ready = !ld_reg`.
  - On `wb_valid && wb_ready`, register `DR=wb_dr`, `data=wb_data`, `ld_reg=1`.
  - Next cycle: `ld_reg=0`, and `pending[wb_dr]` clears in that same edge as the pulse ends. `DR`/`data` hold until the next accepted writeback.
  - A writeback to a non-pending register is written normally; the clear is a no-op.
- **Scoreboard**: when a set and a clear hit the same register in the same edge, set wins.
- The writeback path is independent of the issue FSM; both can progress in the same cycle.

## Timing
- Reset (`reset_n=0` at an edge):
  - State returns to IDLE; `pending`, `ld_reg`, `op_valid`, `op_*`, `SR1`, `SR2`, `DR` and `data` are all cleared to 0.
  - `instr_ready` and `wb_ready` are forced to 0 while `reset_n=0`. Both return to 1 in the first cycle after release.
- Reset mid-operation abandons any in-flight instruction and writeback. If the pulse has not yet occurred, `ld_reg` never pulses. If reset lands in the pulse cycle, the pulse is truncated to that cycle.
- Issue latency with no hazard: accepted at cycle t, HAZARD at t+1, PRIME at t+2, SETTLE at t+3, `op_valid` at t+4. Peak rate is one instruction per 5 cycles.
- Each stall cycle in HAZARD adds 1 cycle. A clear taking effect at edge e allows PRIME at the cycle after e.
- Writeback: accepted at cycle t, `ld_reg=1` throughout t+1, `wb_ready=1` again at t+2. Peak rate is one writeback per 2 cycles.
- `instr_ready=0` outside IDLE. `op_valid` stays high until `op_ready`; `op_*` never change while `op_valid=1`.

## Test plan
- **Reset and simple issue**: reset, preload regfile R1=0x0005, R2=0x0003; issue ADD R3,R1,R2 (0x1642) with `op_ready=1` -> `op_valid` at t+4, `op_a=0x0005`, `op_b=0x0003`, `op_dr=3`, `op_wr=1`, `pending=0x08`.
- **Writeback pulse**: `wb_valid` with `wb_dr=3`, `wb_data=0x0008` -> `ld_reg` high exactly one cycle, `DR=3`, `data=0x0008` held; then `pending=0x00`, regfile R3=0x0008.
- **RAW stall**: issue ADD R3,R1,R2, then ADD R4,R3,R3 (0x18C3) -> second instruction holds in HAZARD until the R3 writeback of 0x0008; `op_a=op_b=0x0008`, never stale.
- **Same-select refresh**: two consecutive NOT R5,R1 with a writeback R1=0x1234 between them -> second `op_a=0x1234`.
- **Unused fields and store**: ADD immediate (0x1261) -> `op_b=0`; STR R2,R1,#0 (0x7440) -> `op_a`=R1, `op_b`=R2, `op_wr=0`, `pending` unchanged; LEA R0 -> `op_wr=1`, no stall on sources.
- **Reset mid-flight**: assert `reset_n=0` during SETTLE and in the `ld_reg` cycle -> next cycle `op_valid=0`, `ld_reg=0`, `pending=0`; the first post-reset instruction is accepted normally.
